// File: rtl/down_counter_timer_pkg.sv
// rtl/down_counter_timer_pkg.sv - shared constants and types for the down-counter/timer
package down_counter_timer_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // 2'b11 is not a named state; the FSM decodes it as IDLE
  typedef enum logic [1:0] {
    ST_IDLE = 2'b00,
    ST_RUN  = 2'b01,
    ST_HOLD = 2'b10
  } state_t;

  typedef enum logic [2:0] {
    CMD_NONE   = 3'd0,
    CMD_LOAD   = 3'd1,
    CMD_DEC    = 3'd2,
    CMD_RELOAD = 3'd3,
    CMD_END    = 3'd4
  } core_cmd_t;

endpackage

// File: rtl/down_counter_core.sv
// rtl/down_counter_core.sv - count/reload datapath with registered terminal-count flag
module down_counter_core
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             Reset,
  input  core_cmd_t        cmd,
  input  logic [WIDTH-1:0] load_val,
  output logic [WIDTH-1:0] Q,
  output logic             tc,
  output logic             q_zero,
  output logic             reload_zero
);

  logic [WIDTH-1:0] reload;
  logic             q_one;

  assign q_zero      = (Q == '0);
  assign q_one       = (Q == WIDTH'(1));
  assign reload_zero = (reload == '0);

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) begin
      Q      <= '0;
      reload <= '0;
      tc     <= 1'b0;
    end else begin
      case (cmd)
        CMD_LOAD: begin
          Q      <= load_val;
          reload <= load_val;
          tc     <= 1'b0;
        end
        CMD_DEC: begin
          Q  <= Q - WIDTH'(1);
          tc <= q_one;
        end
        CMD_RELOAD: begin
          Q  <= reload;
          tc <= 1'b0;
        end
        CMD_END: tc <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: rtl/down_counter_timer.sv
// rtl/down_counter_timer.sv - programmable down-counter/timer with hold and auto-reload
module down_counter_timer
  import down_counter_timer_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clock,
  input  logic             Reset,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             start,
  input  logic             stop,
  input  logic             auto_reload,
  output logic [WIDTH-1:0] Q,
  output logic             busy,
  output logic             tc
);

  state_t    state, state_n;
  core_cmd_t cmd;
  logic      q_zero, reload_zero;

  always_ff @(posedge clock or negedge Reset) begin
    if (!Reset) state <= ST_IDLE;
    else        state <= state_n;
  end

  // priority: load > stop > start
  always_comb begin
    state_n = state;
    cmd     = CMD_NONE;
    if (load) begin
      cmd     = CMD_LOAD;
      state_n = ST_IDLE;
    end else begin
      case (state)
        ST_RUN: begin
          if (stop) begin
            state_n = ST_HOLD;
          end else if (!q_zero) begin
            cmd = CMD_DEC;
          end else if (auto_reload && !reload_zero) begin
            cmd = CMD_RELOAD;
          end else begin
            cmd     = CMD_END;
            state_n = ST_IDLE;
          end
        end
        ST_HOLD: begin
          if (!stop && start) state_n = ST_RUN;
        end
        default: begin
          state_n = ST_IDLE;
          if (!stop && start && !q_zero) state_n = ST_RUN;
        end
      endcase
    end
  end

  assign busy = (state == ST_RUN) || (state == ST_HOLD);

  down_counter_core #(.WIDTH(WIDTH)) u_core (
    .clock       (clock),
    .Reset       (Reset),
    .cmd         (cmd),
    .load_val    (load_val),
    .Q           (Q),
    .tc          (tc),
    .q_zero      (q_zero),
    .reload_zero (reload_zero)
  );

endmodule
